// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the PLL lock / reset sequencer.
// State encoding is fixed so other blocks can decode it.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int unsigned DEF_RST_PULSE      = 16;
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;
    localparam int unsigned DEF_HOLD_CYCLES    = 4096;
    localparam int unsigned DEF_CNT_W          = 21;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// PLL control/status bundle plus the downstream reset outputs.
// master = sequencer side, slave = PLL and downstream side.
interface pll_lock_reset_seq_if;

    logic       pll_lock;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       ready;
    logic [7:0] retry_count;

    modport master (
        input  pll_lock,
        output pll_reset,
        output sys_reset_n,
        output ready,
        output retry_count
    );

    modport slave (
        output pll_lock,
        input  pll_reset,
        input  sys_reset_n,
        input  ready,
        input  retry_count
    );

endinterface

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
// Single-bit two-flop synchronizer, reset to 0.
// Shared by the clock-crossing blocks of the design.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Drives PLL reset, qualifies LOCK and releases a clean downstream reset.
// Runs on the board clock, so it keeps working while the PLL is unlocked.
module pll_lock_reset_seq
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_PULSE      = DEF_RST_PULSE,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pll_lock_reset_seq_if.master pll
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] stab;
    logic [CNT_W-1:0] stab_nxt;
    logic             retry_evt;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll.pll_lock),
        .q       (lock_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + ONE;
        stab_nxt  = stab;
        retry_evt = 1'b0;
        unique case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    stab_nxt  = '0;
                end
            end
            WAIT_LOCK: begin
                // any low cycle restarts qualification; timeout keeps running
                stab_nxt = lock_s ? stab + ONE : '0;
                if (lock_s && stab == STB_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = '0;
                    retry_evt = 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = '0;
                    retry_evt = 1'b1;
                end else if (cnt == HLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = cnt;
                if (!lock_s) begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = '0;
                    retry_evt = 1'b1;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase
    end

    // outputs decode next state so they change on the transition edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RESET_PLL;
            cnt             <= '0;
            stab            <= '0;
            pll.pll_reset   <= 1'b1;
            pll.sys_reset_n <= 1'b0;
            pll.ready       <= 1'b0;
            pll.retry_count <= 8'd0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            stab            <= stab_nxt;
            pll.pll_reset   <= (state_nxt == RESET_PLL);
            pll.sys_reset_n <= (state_nxt == RUN);
            pll.ready       <= (state_nxt == RUN);
            if (retry_evt) begin
                pll.retry_count <= sat_inc(pll.retry_count);
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed scoreboard bench for pll_lock_reset_seq.
// Small timing parameters keep every scenario short.
module tb_pll_lock_reset_seq;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sys_hi_seen = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;
    exp_t sb[$];

    pll_lock_reset_seq_if bus ();

    pll_lock_reset_seq #(
        .RST_PULSE      (4),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (64),
        .HOLD_CYCLES    (16),
        .CNT_W          (21)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pll     (bus.master)
    );

    always #5 clk = ~clk;

    function automatic int st(input logic pr, input logic sr,
                              input logic rd, input int rc);
        logic [7:0] r;
        r = rc[7:0];
        return int'({pr, sr, rd, r});
    endfunction

    function automatic int pack();
        return int'({bus.pll_reset, bus.sys_reset_n, bus.ready,
                     bus.retry_count});
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.pll_reset;
            1:       return bus.sys_reset_n;
            default: return bus.ready;
        endcase
    endfunction

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
            if (bus.sys_reset_n) sys_hi_seen = 1'b1;
        end
    endtask

    task automatic edges_until(input int sel, input logic lvl,
                               input int limit, output int cnt);
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (sig(sel) !== lvl && cnt < limit);
    endtask

    task automatic push(input string tag, input int v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_check(input int obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        bus.pll_lock = 1'b0;
        tick(2);
        reset_n = 1'b1;
        sys_hi_seen = 1'b0;
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        reset_n = 1'b0;
        tick(2);
        push("reset_state", st(1'b1, 1'b0, 1'b0, 0));
        pop_check(pack());

        // clean lock
        reset_n = 1'b1;
        push("rst_pulse_len", 4);
        edges_until(0, 1'b0, 50, n);
        pop_check(n);
        tick(6);
        bus.pll_lock = 1'b1;
        push("clean_lock_latency", 26);
        tick(1);
        edges_until(1, 1'b1, 200, n);
        pop_check(n);
        push("clean_run_state", st(1'b0, 1'b1, 1'b1, 0));
        pop_check(pack());

        // lock loss in RUN, 3 cycles low
        bus.pll_lock = 1'b0;
        push("run_loss_latency", 2);
        tick(1);
        edges_until(1, 1'b0, 20, n);
        pop_check(n);
        push("run_loss_state", st(1'b1, 1'b0, 1'b0, 1));
        pop_check(pack());
        bus.pll_lock = 1'b1;
        push("relock_state", st(1'b0, 1'b1, 1'b1, 1));
        edges_until(2, 1'b1, 200, n);
        pop_check(pack());

        // glitchy lock restarts qualification
        reset_dut();
        edges_until(0, 1'b0, 50, n);
        bus.pll_lock = 1'b1;
        tick(5);
        bus.pll_lock = 1'b0;
        tick(1);
        bus.pll_lock = 1'b1;
        push("glitch_latency", 26);
        tick(1);
        edges_until(1, 1'b1, 200, n);
        pop_check(n);
        push("glitch_retry", 0);
        pop_check(int'(bus.retry_count));

        // timeouts with lock held low
        reset_dut();
        edges_until(0, 1'b0, 50, n);
        for (int k = 1; k <= 3; k++) begin
            push("timeout_gap", 64);
            edges_until(0, 1'b1, 200, n);
            pop_check(n);
            push("timeout_retry", k);
            pop_check(int'(bus.retry_count));
            push("timeout_pulse_len", 4);
            edges_until(0, 1'b0, 50, n);
            pop_check(n);
        end
        push("timeout_sys_low", 0);
        pop_check(int'(sys_hi_seen));

        // lock loss at hold cycle 10
        reset_dut();
        edges_until(0, 1'b0, 50, n);
        bus.pll_lock = 1'b1;
        tick(1);
        tick(19);
        bus.pll_lock = 1'b0;
        tick(3);
        push("hold_loss_state", st(1'b1, 1'b0, 1'b0, 1));
        pop_check(pack());
        tick(40);
        push("hold_sys_never_high", 0);
        pop_check(int'(sys_hi_seen));

        // async reset mid-RUN
        reset_dut();
        bus.pll_lock = 1'b1;
        push("async_pre_run", st(1'b0, 1'b1, 1'b1, 0));
        edges_until(2, 1'b1, 200, n);
        pop_check(pack());
        #3;
        reset_n = 1'b0;
        #1;
        push("async_reset_state", st(1'b1, 1'b0, 1'b0, 0));
        pop_check(pack());

        // 300 timeouts saturate the retry counter
        bus.pll_lock = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(300 * 68 + 20);
        push("retry_saturated", 255);
        pop_check(int'(bus.retry_count));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
- Consumer end of the PLL interface. Drives the PLL's RESET input and monitors its asynchronous LOCK output.
- Issues a clean, synchronously released reset to the PSRAM-test logic only after lock has been stable and a post-lock hold time has elapsed.
- Runs on the 27 MHz board clock (PLL input), never on a PLL output. Re-sequences automatically on lock timeout or lock loss.

Parameters:
- RST_PULSE, 16: cycles pll_reset is held high per attempt.
- STABLE_CYCLES, 1024: consecutive synchronized lock-high cycles needed to accept lock.
- TIMEOUT_CYCLES, 1048576: cycles in WAIT_LOCK before retrying the PLL reset.
- HOLD_CYCLES, 4096: cycles sys_reset_n stays low after lock is accepted (at least 150 us PSRAM power-up).
- CNT_W, 21: width of the shared down/up counter. Must satisfy 2^CNT_W > max of all cycle parameters.

Ports:
- clk, input, 1: 27 MHz board clock.
- reset_n, input, 1: asynchronous active-low reset.
- pll_lock, input, 1: PLL LOCK. Asynchronous to clk.
- pll_reset, output, 1: to PLL RESET, active-high.
- sys_reset_n, output, 1: downstream reset, active-low. Asserted asynchronously with reset_n, released synchronously.
- ready, output, 1: high in RUN only.
- retry_count, output, 8: saturating count of timeouts plus lock losses.

Behaviour:
- Reset values (reset_n=0):
  - state=RESET_PLL, counter=0.
  - pll_reset=1, sys_reset_n=0, ready=0, retry_count=0.
  - Synchronizer flops = 0.
- Lock synchronization: pll_lock passes a 2-flop synchronizer; lock_s is its output. All decisions use lock_s only.
- RESET_PLL:
  - pll_reset=1, sys_reset_n=0.
  - Count RST_PULSE cycles, then go to WAIT_LOCK with counters cleared.
- WAIT_LOCK:
  - pll_reset=0.
  - Stable counter increments while lock_s=1 and clears to 0 on any lock_s=0 cycle (glitch restarts qualification).
  - Timeout counter increments every cycle and is not cleared by glitches.
  - Stable count reaching STABLE_CYCLES → HOLD.
  - Otherwise, timeout reaching TIMEOUT_CYCLES → RESET_PLL and retry_count+1.
  - If both occur in the same cycle, stable wins.
- HOLD:
  - sys_reset_n=0. Count HOLD_CYCLES, then go to RUN.
  - lock_s=0 at any point → RESET_PLL and retry_count+1.
- RUN:
  - sys_reset_n=1, ready=1.
  - lock_s=0 for one cycle → RESET_PLL and retry_count+1. sys_reset_n and ready drop on that same edge.
- Latency: with pll_lock held high, sys_reset_n rises exactly 2+STABLE_CYCLES+HOLD_CYCLES edges after the first edge that samples pll_lock=1 in WAIT_LOCK.
- retry_count saturates at 255, with no wrap.
- sys_reset_n and ready are registered outputs with no combinational path from pll_lock.
- reset_n asserted mid-operation: outputs go to reset values immediately (asynchronously).
- Deassertion of reset_n starts a fresh RESET_PLL pulse.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - 2-bit state encoding constants: RESET_PLL=0, WAIT_LOCK=1, HOLD=2, RUN=3.
  - Default cycle constants.
- One sub-module: sync_2ff (1-bit two-flop synchronizer, clk and reset_n, reset value 0). It is reused by other clock-crossing blocks.

Test Plan (parameters RST_PULSE=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=64, HOLD_CYCLES=16):
- Clean lock: release reset_n, raise pll_lock 10 cycles later.
  - pll_reset high for exactly 4 cycles.
  - sys_reset_n rises 26 edges after lock is first sampled.
  - retry_count=0.
- Glitchy lock: pll_lock high 5 cycles, low 1, then high. Qualification restarts, so sys_reset_n rises 26 edges after the second rising edge.
- Timeout: pll_lock held low.
  - A 4-cycle pll_reset pulse every 68 cycles.
  - retry_count increments 1, 2, 3.
  - sys_reset_n stays 0.
- Lock loss in RUN: drop pll_lock for 3 cycles.
  - sys_reset_n=0 and ready=0 on the 2nd edge after the drop.
  - pll_reset pulses, retry_count=1.
  - Re-lock yields ready again.
- Loss during HOLD: drop lock at hold cycle 10 → RESET_PLL, sys_reset_n never pulses high, retry_count=1.
- Async reset mid-RUN and saturation:
  - Assert reset_n between edges → sys_reset_n=0 before the next edge.
  - Force 300 timeouts → retry_count holds at 255.
